demux_1to2_reg: RTL and testbench

// - Registered 1-to-2 demultiplexer for a valid/ready data stream.
// - Steers each accepted input beat to output 0 or 1, selected by in_sel
//   and sampled with the beat.
// - Each output has its own one-entry holding register.
// - Sits downstream of a stream source. Fans it out to two consumers.
//   It is the inverse of the 2:1 mux path.

---
 rtl/demux_1to2_reg.sv | 79 +++++++
 tb/tb_demux_1to2_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 valid/ready demultiplexer with a one-entry holding register per output.
// Optional per-output accepted-beat counters are enabled by defining DEMUX_CNT_EN.
module demux_1to2_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_invalid
  end

  logic free0;
  logic free1;
  logic load0;
  logic load1;

  // A slot can take a new beat when it is empty or is being drained this cycle.
  always_comb begin
    free0    = !out0_valid || out0_ready;
    free1    = !out1_valid || out1_ready;
    in_ready = in_sel ? free1 : free0;
    load0    = in_valid && in_ready && !in_sel;
    load1    = in_valid && in_ready &&  in_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (load0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (load1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef DEMUX_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (load0) cnt0 <= cnt0 + CNT_W'(1);
      if (load1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Bench for demux_1to2_reg: slot-level behavioural model checked every cycle plus directed literal checks.
module tb_demux_1to2_reg;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_sel = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             out0_valid, out1_valid;
  logic             out0_ready = 1'b1;
  logic             out1_ready = 1'b1;
`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0, cnt1;
`endif

  demux_1to2_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_sel(in_sel), .in_ready(in_ready),
    .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready)
`ifdef DEMUX_CNT_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: each output is a slot that is either empty or holds one beat.
  logic             m_valid [2];
  logic [WIDTH-1:0] m_data  [2];
  int               m_cnt   [2];

  function automatic logic m_slot_free(input int k);
    logic rdy;
    rdy = (k == 0) ? out0_ready : out1_ready;
    return !m_valid[k] || rdy;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= '0;
        m_cnt[k]   <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (in_valid && m_slot_free(int'(in_sel)) && int'(in_sel) == k) begin
          m_valid[k] <= 1'b1;
          m_data[k]  <= in_data;
          m_cnt[k]   <= (m_cnt[k] + 1) % (1 << CNT_W);
        end else if ((k == 0) ? out0_ready : out1_ready) begin
          m_valid[k] <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready",   32'(in_ready),   32'(m_slot_free(int'(in_sel))));
    chk("out0_valid", 32'(out0_valid), 32'(m_valid[0]));
    chk("out0_data",  32'(out0_data),  32'(m_data[0]));
    chk("out1_valid", 32'(out1_valid), 32'(m_valid[1]));
    chk("out1_data",  32'(out1_data),  32'(m_data[1]));
`ifdef DEMUX_CNT_EN
    chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
    chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    drive(1'b1, 1'b0, 8'hFF);
    cyc(); cyc();
    chk("rst_out0_valid", 32'(out0_valid), 32'd0);
    chk("rst_out0_data",  32'(out0_data),  32'd0);
    chk("rst_out1_valid", 32'(out1_valid), 32'd0);
    chk("rst_out1_data",  32'(out1_data),  32'd0);
    drive(1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    cyc();

    // Steering
    drive(1'b1, 1'b0, 8'hA5);
    cyc();
    chk("steer_out0_valid", 32'(out0_valid), 32'd1);
    chk("steer_out0_data",  32'(out0_data),  32'hA5);
    drive(1'b1, 1'b1, 8'h3C);
    cyc();
    chk("steer_out1_valid", 32'(out1_valid), 32'd1);
    chk("steer_out1_data",  32'(out1_data),  32'h3C);
    chk("steer_out0_drained", 32'(out0_valid), 32'd0);
    drive(1'b0, 1'b0, 8'h00);
    cyc();

    // Back-pressure, then independence while out0 stalls full
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    cyc();
    chk("bp_out0_data", 32'(out0_data), 32'h11);
    drive(1'b1, 1'b0, 8'h22);
    #1 chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    cyc();
    chk("bp_out0_hold", 32'(out0_data), 32'h11);
    drive(1'b1, 1'b1, 8'h55);
    #1 chk("ind_in_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("ind_out1_data",  32'(out1_data),  32'h55);
    chk("ind_out0_valid", 32'(out0_valid), 32'd1);
    chk("ind_out0_data",  32'(out0_data),  32'h11);
    drive(1'b1, 1'b0, 8'h22);
    #1 chk("bp_still_low", 32'(in_ready), 32'd0);
    out0_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    chk("bp_out0_second", 32'(out0_data), 32'h22);
    drive(1'b0, 1'b0, 8'h00);
    cyc();
    chk("bp_out0_empty", 32'(out0_valid), 32'd0);

    // Streaming back-to-back
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 8'(i));
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      cyc();
      chk("stream_out0_data", 32'(out0_data), 32'(i));
    end
    drive(1'b0, 1'b0, 8'h00);
    cyc();

`ifdef DEMUX_CNT_EN
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'(8'h80 + i));
      cyc();
    end
    drive(1'b0, 1'b0, 8'h00);
    chk("cnt1_wrapped", 32'(cnt1), 32'd1);
    chk("cnt0_zero",    32'(cnt0), 32'd0);
`endif

    // Pseudo-random traffic, checked by the model every cycle
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      out0_ready = 1'($urandom_range(0, 1));
      out1_ready = 1'($urandom_range(0, 1));
      cyc();
    end

    // Async reset mid-stream
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    cyc();
    drive(1'b1, 1'b1, 8'h66);
    cyc();
    rst_n = 1'b0;
    #1;
    chk("arst_out0_valid", 32'(out0_valid), 32'd0);
    chk("arst_out0_data",  32'(out0_data),  32'd0);
    chk("arst_out1_valid", 32'(out1_valid), 32'd0);
    chk("arst_out1_data",  32'(out1_data),  32'd0);
`ifdef DEMUX_CNT_EN
    chk("arst_cnt0", 32'(cnt0), 32'd0);
    chk("arst_cnt1", 32'(cnt1), 32'd0);
`endif
    cyc();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00);
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
